// File: rtl/peripheral_dbg_soc_osd_uart_terminal_pkg.sv
// Shared types for the UART terminal bridge: the DII flit and the OSD event
// constants plus the FSM state encodings used by the terminal endpoint.
package dii_package;

    typedef struct packed {
        logic        valid;
        logic        last;
        logic [15:0] data;
    } dii_flit;

endpackage

package peripheral_dbg_soc_osd_uart_terminal_pkg;

    localparam logic [1:0]  TYPE_EVENT          = 2'b10;
    localparam logic [3:0]  TYPE_SUB_EVENT_LAST = 4'b0000;
    localparam logic [15:0] EVENT_FLAGS         = 16'h8000;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_DEST,
        TX_SRC,
        TX_FLAGS,
        TX_XFER
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_DEST,
        RX_SRC,
        RX_FLAGS,
        RX_PAYLOAD,
        RX_DISCARD
    } rx_state_t;

endpackage

// File: rtl/peripheral_dbg_soc_osd_uart_terminal_fifo.sv
// Byte-wide synchronous FIFO holding received characters until the host takes them.
module peripheral_dbg_soc_osd_uart_terminal_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       push,
    output logic       full,
    output logic [7:0] dout,
    input  logic       pop,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    // Head entry is masked while empty so the output is defined straight out of reset.
    assign dout    = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/peripheral_dbg_soc_osd_uart_terminal.sv
// DII endpoint bridging DEM-UART event packets to a host byte stream and
// packing host keystrokes into event packets for the paired DEM-UART.
module peripheral_dbg_soc_osd_uart_terminal
    import dii_package::*;
    import peripheral_dbg_soc_osd_uart_terminal_pkg::*;
#(
    parameter int RX_FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] id,
    input  logic [15:0] target_id,
    input  dii_flit     debug_in,
    output logic        debug_in_ready,
    output dii_flit     debug_out,
    input  logic        debug_out_ready,
    output logic [7:0]  rx_char,
    output logic        rx_valid,
    input  logic        rx_ready,
    input  logic [7:0]  tx_char,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  err_count
);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    tx_state_t  tx_state;
    tx_state_t  tx_next;
    logic [7:0] tx_char_q;

    always_ff @(posedge clk) begin
        if (rst) tx_state <= TX_IDLE;
        else     tx_state <= tx_next;
    end

    always_ff @(posedge clk) begin
        if (tx_state == TX_IDLE && tx_valid) tx_char_q <= tx_char;
    end

    // Flit contents depend on state only; debug_out_ready just advances the state.
    always_comb begin
        tx_next   = tx_state;
        debug_out = '0;
        tx_ready  = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                tx_ready = 1'b1;
                if (tx_valid) tx_next = TX_DEST;
            end
            TX_DEST: begin
                debug_out.valid = 1'b1;
                debug_out.data  = target_id;
                if (debug_out_ready) tx_next = TX_SRC;
            end
            TX_SRC: begin
                debug_out.valid = 1'b1;
                debug_out.data  = id;
                if (debug_out_ready) tx_next = TX_FLAGS;
            end
            TX_FLAGS: begin
                debug_out.valid = 1'b1;
                debug_out.data  = EVENT_FLAGS;
                if (debug_out_ready) tx_next = TX_XFER;
            end
            TX_XFER: begin
                debug_out.valid = 1'b1;
                debug_out.last  = 1'b1;
                debug_out.data  = {8'h00, tx_char_q};
                if (debug_out_ready) tx_next = TX_IDLE;
            end
            default: tx_next = TX_IDLE;
        endcase
    end

    rx_state_t rx_state;
    rx_state_t rx_next;
    logic      hdr_bad;
    logic      hdr_bad_next;
    logic      hdr_mismatch;
    logic      bad_now;
    logic      in_fire;
    logic      err_inc;
    logic      fifo_push;
    logic      fifo_full;
    logic      fifo_empty;

    assign in_fire = debug_in.valid & debug_in_ready;

    always_comb begin
        hdr_mismatch = 1'b0;
        case (rx_state)
            RX_DEST:  hdr_mismatch = (debug_in.data != id);
            RX_SRC:   hdr_mismatch = (debug_in.data != target_id);
            RX_FLAGS: hdr_mismatch = (debug_in.data[15:10] != {TYPE_EVENT, TYPE_SUB_EVENT_LAST});
            default:  hdr_mismatch = 1'b0;
        endcase
    end

    // A header flit carrying last always makes the packet bad.
    assign bad_now = hdr_bad | hdr_mismatch | debug_in.last;

    always_comb begin
        rx_next        = rx_state;
        hdr_bad_next   = hdr_bad;
        err_inc        = 1'b0;
        debug_in_ready = 1'b1;
        fifo_push      = 1'b0;
        case (rx_state)
            RX_DEST, RX_SRC, RX_FLAGS: begin
                if (in_fire) begin
                    if (debug_in.last) begin
                        err_inc      = 1'b1;
                        hdr_bad_next = 1'b0;
                        rx_next      = RX_DEST;
                    end else if (rx_state == RX_FLAGS) begin
                        hdr_bad_next = 1'b0;
                        if (bad_now) begin
                            err_inc = 1'b1;
                            rx_next = RX_DISCARD;
                        end else begin
                            rx_next = RX_PAYLOAD;
                        end
                    end else begin
                        hdr_bad_next = bad_now;
                        rx_next      = (rx_state == RX_DEST) ? RX_SRC : RX_FLAGS;
                    end
                end
            end
            RX_PAYLOAD: begin
                debug_in_ready = ~fifo_full;
                fifo_push      = in_fire;
                if (in_fire && debug_in.last) rx_next = RX_DEST;
            end
            RX_DISCARD: begin
                if (in_fire && debug_in.last) rx_next = RX_DEST;
            end
            default: rx_next = RX_DEST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state  <= RX_DEST;
            hdr_bad   <= 1'b0;
            err_count <= 8'h00;
        end else begin
            rx_state <= rx_next;
            hdr_bad  <= hdr_bad_next;
            if (err_inc) err_count <= sat_inc(err_count);
        end
    end

    peripheral_dbg_soc_osd_uart_terminal_fifo #(
        .DEPTH(RX_FIFO_DEPTH)
    ) u_rx_fifo (
        .clk  (clk),
        .rst  (rst),
        .din  (debug_in.data[7:0]),
        .push (fifo_push),
        .full (fifo_full),
        .dout (rx_char),
        .pop  (rx_ready),
        .empty(fifo_empty)
    );

    assign rx_valid = ~fifo_empty;

endmodule

// File: tb/tb_peripheral_dbg_soc_osd_uart_terminal.sv
// Directed and randomized bench for the UART terminal bridge, checked against
// packet-level queues of expected flits and characters.
module tb_peripheral_dbg_soc_osd_uart_terminal;
    import dii_package::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] id        = 16'h0010;
    logic [15:0] target_id = 16'h0005;
    dii_flit     debug_in;
    logic        debug_in_ready;
    dii_flit     debug_out;
    logic        debug_out_ready;
    logic [7:0]  rx_char;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_char;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  err_count;

    always #5 clk = ~clk;

    peripheral_dbg_soc_osd_uart_terminal #(.RX_FIFO_DEPTH(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .id             (id),
        .target_id      (target_id),
        .debug_in       (debug_in),
        .debug_in_ready (debug_in_ready),
        .debug_out      (debug_out),
        .debug_out_ready(debug_out_ready),
        .rx_char        (rx_char),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .tx_char        (tx_char),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .err_count      (err_count)
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [16:0] send_q[$];
    logic [7:0]  exp_q[$];
    logic [16:0] txe_q[$];
    int          err_exp = 0;
    int          rx_pol  = 0;
    int          tx_pol  = 0;
    int          or_pol  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: a packet is delivered only if dest, src and event flags all match
    // and no header flit carries last; every bad packet bumps the error count once.
    task automatic add_pkt(input logic [15:0] d, input logic [15:0] s, input logic [15:0] f,
                           input int hl, input int np, input int c0);
        logic [16:0] fl[$];
        logic [7:0]  cs[$];
        logic        bad;
        logic [7:0]  c;
        bad = (d != id) || (s != target_id) || (f[15:10] != 6'b100000) || (hl >= 0);
        fl.push_back({1'b0, d});
        fl.push_back({1'b0, s});
        fl.push_back({1'b0, f});
        if (hl >= 0) begin
            while (fl.size() > hl + 1) void'(fl.pop_back());
            fl[hl][16] = 1'b1;
        end else begin
            for (int k = 0; k < np; k++) begin
                c = (k == 0 && c0 >= 0) ? 8'(c0) : 8'($urandom_range(0, 255));
                cs.push_back(c);
                fl.push_back({(k == np - 1), 8'($urandom_range(0, 255)), c});
            end
        end
        if (bad) begin
            if (err_exp < 255) err_exp++;
        end else begin
            foreach (cs[k]) exp_q.push_back(cs[k]);
        end
        foreach (fl[k]) send_q.push_back(fl[k]);
    endtask

    task automatic sample();
        if (rx_valid && rx_ready) begin
            chk("rx_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("rx_char", 32'(rx_char), 32'(exp_q.pop_front()));
        end
        if (debug_out.valid && debug_out_ready) begin
            chk("tx_expected", 32'(txe_q.size() != 0), 32'd1);
            if (txe_q.size() != 0) chk("tx_flit", 32'({debug_out.last, debug_out.data}), 32'(txe_q.pop_front()));
        end
        if (debug_in.valid && debug_in_ready && send_q.size() != 0) void'(send_q.pop_front());
        if (tx_valid && tx_ready) begin
            txe_q.push_back({1'b0, target_id});
            txe_q.push_back({1'b0, id});
            txe_q.push_back(17'h08000);
            txe_q.push_back({1'b1, 8'h00, tx_char});
        end
    endtask

    task automatic drive();
        if (send_q.size() != 0) debug_in = {1'b1, send_q[0]};
        else                    debug_in = '0;
        rx_ready        = (rx_pol == 2) ? 1'($urandom_range(0, 1)) : (rx_pol == 1);
        tx_valid        = (tx_pol == 2) ? 1'($urandom_range(0, 1)) : (tx_pol == 1);
        tx_char         = 8'($urandom_range(0, 255));
        debug_out_ready = (or_pol == 2) ? 1'($urandom_range(0, 1)) : (or_pol == 1);
    endtask

    task automatic tick_rest();
        sample();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic tick();
        @(negedge clk);
        tick_rest();
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((send_q.size() != 0 || exp_q.size() != 0 || txe_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_drained"}, 32'(n < budget), 32'd1);
    endtask

    logic [16:0] tx_ref[4];
    int          n;

    initial begin
        tx_ref = '{17'h00005, 17'h00010, 17'h08000, 17'h10041};
        rst = 1'b1;
        debug_in = '0;
        debug_out_ready = 1'b0;
        rx_ready = 1'b0;
        tx_char = 8'h00;
        tx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_rx_char", 32'(rx_char), 32'd0);
        chk("rst_out_valid", 32'(debug_out.valid), 32'd0);
        chk("rst_out_last", 32'(debug_out.last), 32'd0);
        chk("rst_out_data", 32'(debug_out.data), 32'd0);
        chk("rst_tx_ready", 32'(tx_ready), 32'd1);
        chk("rst_in_ready", 32'(debug_in_ready), 32'd1);
        chk("rst_err", 32'(err_count), 32'd0);
        tick_rest();

        // Directed TX of 'A'
        tx_char = 8'h41;
        tx_valid = 1'b1;
        debug_out_ready = 1'b1;
        or_pol = 1;
        @(negedge clk);
        chk("tx_hs_ready", 32'(tx_ready), 32'd1);
        tick_rest();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("tx_dir_valid", 32'(debug_out.valid), 32'd1);
            chk("tx_dir_flit", 32'({debug_out.last, debug_out.data}), 32'(tx_ref[k]));
            chk("tx_dir_busy", 32'(tx_ready), 32'd0);
            tick_rest();
        end
        @(negedge clk);
        chk("tx_dir_done_ready", 32'(tx_ready), 32'd1);
        chk("tx_dir_done_valid", 32'(debug_out.valid), 32'd0);
        tick_rest();

        // Directed RX of 'H'
        rx_pol = 1;
        add_pkt(id, target_id, 16'h8000, -1, 1, 8'h48);
        n = 0;
        while (send_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        chk("rx_dir_sent", 32'(n < 50), 32'd1);
        @(negedge clk);
        chk("rx_dir_valid", 32'(rx_valid), 32'd1);
        chk("rx_dir_char", 32'(rx_char), 32'h48);
        tick_rest();
        @(negedge clk);
        chk("rx_dir_one_cycle", 32'(rx_valid), 32'd0);
        chk("rx_dir_err", 32'(err_count), 32'd0);
        tick_rest();

        // Bad dest, bad flags, then a good packet
        add_pkt(16'h0011, target_id, 16'h8000, -1, 1, -1);
        add_pkt(id, target_id, 16'h0000, -1, 1, -1);
        drain("bad_pair", 200);
        chk("bad_pair_err", 32'(err_count), 32'd2);
        add_pkt(id, target_id, 16'h8000, -1, 2, -1);
        drain("good_after_bad", 200);
        chk("good_after_bad_err", 32'(err_count), 32'd2);

        // FIFO full with host stalled
        rx_pol = 0;
        for (int k = 0; k < 10; k++) add_pkt(id, target_id, 16'h8000, -1, 1, -1);
        repeat (60) tick();
        @(negedge clk);
        chk("full_in_ready", 32'(debug_in_ready), 32'd0);
        chk("full_pending", 32'(send_q.size()), 32'd5);
        chk("full_rx_valid", 32'(rx_valid), 32'd1);
        rx_pol = 1;
        tick_rest();
        @(negedge clk);
        chk("full_pop_cycle_ready", 32'(debug_in_ready), 32'd0);
        tick_rest();
        @(negedge clk);
        chk("full_after_pop_ready", 32'(debug_in_ready), 32'd1);
        tick_rest();
        drain("full_drain", 300);

        // Last on the flags flit, then a good packet
        add_pkt(id, target_id, 16'h8000, 2, 0, -1);
        add_pkt(id, target_id, 16'h8000, -1, 1, -1);
        drain("hdr_last", 200);
        chk("hdr_last_err", 32'(err_count), 32'(err_exp));

        // Randomized traffic on both paths
        rx_pol = 2;
        tx_pol = 2;
        or_pol = 2;
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 5))
                0: add_pkt(16'($urandom_range(0, 65535)) | 16'h0100, target_id, 16'h8000, -1, 1, -1);
                1: add_pkt(id, 16'h0006, 16'h8000, -1, 2, -1);
                2: add_pkt(id, target_id, 16'($urandom_range(0, 65535)) & 16'h7FFF, -1, 1, -1);
                3: add_pkt(id, target_id, 16'h8000, $urandom_range(0, 2), 0, -1);
                4: add_pkt(id, target_id, 16'h8000 | 16'($urandom_range(0, 1023)), -1, $urandom_range(1, 4), -1);
                default: add_pkt(id, target_id, 16'h8000, -1, $urandom_range(1, 12), -1);
            endcase
        end
        repeat (200) tick();
        tx_pol = 0;
        drain("random", 4000);
        chk("random_err", 32'(err_count), 32'(err_exp));

        // Error counter saturation
        or_pol = 1;
        rx_pol = 1;
        for (int k = 0; k < 260; k++) add_pkt(id, target_id, 16'h8000, 0, 0, -1);
        drain("saturate", 2000);
        chk("saturate_err", 32'(err_count), 32'd255);

        // Reset during TX_FLAGS with RX stalled mid-payload
        rx_pol = 0;
        add_pkt(id, target_id, 16'h8000, -1, 12, -1);
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (!debug_in_ready) break;
            tick_rest();
            n++;
        end
        chk("mid_rx_stalled", 32'(n < 100), 32'd1);
        tx_pol = 1;
        tick_rest();
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (debug_out.valid && debug_out.data == id) break;
            tick_rest();
            n++;
        end
        chk("mid_tx_src_seen", 32'(n < 20), 32'd1);
        tx_pol = 0;
        tick_rest();
        rst = 1'b1;
        debug_in = '0;
        tx_valid = 1'b0;
        @(negedge clk);
        chk("mid_tx_in_flags", 32'(debug_out.data), 32'h8000);
        @(posedge clk);
        #1 rst = 1'b0;
        send_q.delete();
        exp_q.delete();
        txe_q.delete();
        err_exp = 0;
        @(negedge clk);
        chk("post_rst_out_valid", 32'(debug_out.valid), 32'd0);
        chk("post_rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("post_rst_tx_ready", 32'(tx_ready), 32'd1);
        chk("post_rst_in_ready", 32'(debug_in_ready), 32'd1);
        chk("post_rst_err", 32'(err_count), 32'd0);
        tick_rest();

        // Both paths recover after reset
        rx_pol = 1;
        tx_pol = 1;
        add_pkt(id, target_id, 16'h8000, -1, 3, -1);
        tick();
        tx_pol = 0;
        drain("post_rst", 300);
        chk("post_rst_final_err", 32'(err_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/peripheral_dbg_soc_osd_uart_terminal.md
# peripheral_dbg_soc_osd_uart_terminal

Host-side endpoint of the DEM-UART event protocol on the debug interconnect (DII). Receives single-character event packets emitted by a DEM-UART module, buffers the characters and presents them as a byte stream to the host link. Takes host keystrokes from a byte stream and packs each one into an event packet addressed to the DEM-UART module. Sits on the debug ring next to the host interface as a terminal bridge for hardware-only debug setups.

## Interface
- `RX_FIFO_DEPTH`, 8 — received-character buffer depth; power of two, ≥2.
- `clk` in 1 — single clock.
- `rst` in 1 — synchronous, active-high reset.
- `id` in 16 — this endpoint's DII address; used as src in sent packets and checked against dest in received packets.
- `target_id` in 16 — DII address of the paired DEM-UART module.
- `debug_in` in dii_flit — flits from the interconnect (`valid`, `last`, `data[15:0]`).
- `debug_in_ready` out 1 — flit accept.
- `debug_out` out dii_flit — flits to the interconnect.
- `debug_out_ready` in 1 — interconnect accept.
- `rx_char` out 8 — character to the host.
- `rx_valid` out 1, `rx_ready` in 1 — valid/ready handshake for `rx_char`.
- `tx_char` in 8 — character from the host.
- `tx_valid` in 1, `tx_ready` out 1 — valid/ready handshake for `tx_char`.
- `err_count` out 8 — saturating count of discarded packets.

## Operation
- Packet format, both directions:
  - flit0: dest
  - flit1: src
  - flit2: flags = {type[1:0], subtype[3:0], 10'h0}; event type = 2'b10, subtype = 4'b0000.
  - flit3 and later: payload, one character per flit in `data[7:0]`; the final flit carries `last`.
- A flit transfers when `valid & ready`.
- TX FSM, states TX_IDLE → TX_DEST → TX_SRC → TX_FLAGS → TX_XFER → TX_IDLE:
  - TX_IDLE: `tx_ready`=1. On `tx_valid`, latch `tx_char` and go to TX_DEST.
  - TX_DEST, TX_SRC, TX_FLAGS, TX_XFER drive `target_id`, `id`, 16'h8000 and {8'h0, char} respectively, with `valid`=1.
  - `last`=1 only in TX_XFER.
  - Each state advances on `debug_out_ready`.
  - `tx_ready`=0 outside TX_IDLE.
- RX FSM, states RX_DEST → RX_SRC → RX_FLAGS → RX_PAYLOAD, plus RX_DISCARD:
  - Header flits are always accepted (`debug_in_ready`=1).
  - Packet is bad if any of:
    - dest ≠ `id`
    - src ≠ `target_id`
    - flags[15:10] ≠ 6'b100000
    - `last` seen on flit0–flit2
  - Bad packet: increment `err_count` (saturating at 8'hFF) once per packet. Then enter RX_DISCARD, accepting flits until `last`, unless `last` was already seen; in that case return to RX_DEST.
  - RX_PAYLOAD: `debug_in_ready` = FIFO not full. Each accepted flit pushes `data[7:0]`. `last` returns to RX_DEST.
  - Multi-flit payloads are legal: each flit is one character.
- RX FIFO: holds `RX_FIFO_DEPTH` entries. Occupancy counter is `$clog2(RX_FIFO_DEPTH)+1` bits wide and pointers wrap. `rx_valid` = not empty; `rx_char` = head entry.
- TX and RX paths are fully independent.

## Timing
- Reset values:
  - Both FSMs in their initial state (TX_IDLE, RX_DEST).
  - FIFO empty.
  - `rx_valid`=0, `rx_char`=8'h0.
  - `debug_out.valid`=0, `debug_out.last`=0, `debug_out.data`=16'h0.
  - `tx_ready`=1, `debug_in_ready`=1, `err_count`=0.
- `debug_out`, `tx_ready` and `debug_in_ready` are combinational from state, plus FIFO-full for `debug_in_ready`; no combinational path from `debug_out_ready` to `debug_out`.
- TX latency: first flit valid the cycle after the `tx_valid` handshake. With `debug_out_ready` held high, one character takes 5 cycles, handshake to next `tx_ready`.
- RX latency: `rx_valid` rises the cycle after the payload flit is accepted.
- FIFO full: payload flit stalls with `debug_in_ready`=0; never dropped.
- Push and pop in the same cycle when full: pop frees a slot, but `debug_in_ready` stays 0 that cycle. The flit is accepted the next cycle.
- Push and pop in the same cycle when empty: no bypass; the character appears the next cycle.
- Reset mid-packet abandons any partial packet and clears the FIFO; `err_count` is not incremented.

## Structure
- Package `dii_package` provides `dii_flit`.
- Add to the shared OSD package:
  - `TYPE_EVENT` = 2'b10
  - `TYPE_SUB_EVENT_LAST` = 4'b0000
  - `EVENT_FLAGS` = 16'h8000
- One sub-module: `peripheral_dbg_soc_osd_uart_terminal_fifo` — synchronous FIFO, 8-bit wide, parameter `DEPTH`, with push/pop/full/empty.

## Test plan
- Reset, then `tx_char`=8'h41 with `tx_valid`=1 and `debug_out_ready`=1 → flits 0x0005 (`target_id`), 0x0010 (`id`), 0x8000, 0x0041+`last` on 4 consecutive cycles; `tx_ready` back to 1 on cycle 5.
- Send event packet {0x0010, 0x0005, 0x8000, 0x0048+`last`} with `rx_ready`=1 → `rx_char`=8'h48 for one cycle, one cycle after the last flit; `err_count`=0.
- Send packet with dest=0x0011, then packet with flags 0x0000 (4 flits, `last` on 4th) → both fully consumed, no `rx_valid`, `err_count`=2. A following good packet is delivered.
- Hold `rx_ready`=0, send 10 good packets (DEPTH 8) → `debug_in_ready` low on the 9th payload flit. Releasing `rx_ready` drains characters in order with no loss.
- Packet with `last` on the flags flit → `err_count`+1 and RX returns to RX_DEST. Separately, 256+ bad packets → `err_count` holds 8'hFF.
- Assert `rst` during TX_FLAGS and mid-RX payload → next cycle `debug_out.valid`=0, `rx_valid`=0, `tx_ready`=1.
